// File: rtl/rast_pkg.sv
// Shared types and helpers for the raster sample-walk stage.
//   SIGFIG   : width of a signed fixed-point screen coordinate
//   RADIX    : number of fraction bits in a coordinate
//   ss_w_lg2 : log2 of subsamples per pixel edge from the one-hot subsample mode
//   step_of  : subsample grid pitch in fixed point for a given ss_w_lg2
package rast_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int AXIS   = 3;
    localparam int ONE    = 1 << RADIX;

    typedef enum logic {WAIT, TEST} walk_state_t;

    typedef logic signed [SIGFIG-1:0] fixed_t;

    // Anything that is not one-hot falls back to one sample per pixel.
    function automatic logic [1:0] ss_w_lg2(input logic [3:0] ss);
        case (ss)
            4'b0001: return 2'd3;
            4'b0010: return 2'd2;
            4'b0100: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // ONE >> lg2 is the same value as 1 << (RADIX - lg2).
    function automatic fixed_t step_of(input logic [1:0] lg2);
        return fixed_t'(ONE >> lg2);
    endfunction

endpackage

// File: rtl/sample_step_gen.sv
// Next-sample computation for the raster walk (pure combinational).
//   i_x, i_y     : current sample position
//   i_ll_x       : snapped lower-left x, used as the row restart column
//   i_ur_x/i_ur_y: upper-right corner of the box (inclusive)
//   i_step       : grid pitch
//   o_next_x/y   : position of the following sample
//   o_row_end    : x + step leaves the box, next sample starts a new row
//   o_done       : current sample is the last one of the box
module sample_step_gen
    import rast_pkg::*;
(
    input  fixed_t i_x,
    input  fixed_t i_y,
    input  fixed_t i_ll_x,
    input  fixed_t i_ur_x,
    input  fixed_t i_ur_y,
    input  fixed_t i_step,
    output fixed_t o_next_x,
    output fixed_t o_next_y,
    output logic   o_row_end,
    output logic   o_done
);

    fixed_t w_nx;
    fixed_t w_ny;

    assign w_nx      = i_x + i_step;
    assign w_ny      = i_y + i_step;
    assign o_row_end = (w_nx > i_ur_x);
    assign o_done    = o_row_end && (w_ny > i_ur_y);
    assign o_next_x  = o_row_end ? i_ll_x : w_nx;
    assign o_next_y  = o_row_end ? w_ny : i_y;

endmodule

// File: rtl/sample_walk_ctrl.sv
// Sample-walk controller: accepts one bounding box per triangle and walks it in
// raster order on the subsample grid, one sample per cycle.
//   clk, rst          : clock, synchronous active-low reset
//   validTri_R13H     : bbox valid from the bbox stage
//   box_R13S          : [0]=ll(x,y), [1]=ur(x,y), signed fixed point
//   subSample_RnnnnU  : one-hot subsample mode, [0]=8x8 .. [3]=1x1
//   stall_R15H        : downstream stall, hold current sample
//   halt_R13H         : bbox stage must hold, box not accepted
//   sample_R14S       : current sample (x,y)
//   validSamp_R14H    : sample_R14S valid
//   lastSamp_R14H     : current sample is the final one of the box
//
// state | meaning
// WAIT  | idle, accepts a box when valid and not stalled
// TEST  | walking the box, one sample per unstalled cycle
module sample_walk_ctrl
    import rast_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          validTri_R13H,
    input  logic [1:0][1:0][SIGFIG-1:0]   box_R13S,
    input  logic [3:0]                    subSample_RnnnnU,
    input  logic                          stall_R15H,
    output logic                          halt_R13H,
    output logic [1:0][SIGFIG-1:0]        sample_R14S,
    output logic                          validSamp_R14H,
    output logic                          lastSamp_R14H
);

    walk_state_t r_state;
    logic [1:0]  r_lg2;
    fixed_t      r_ll_x;
    fixed_t      r_ur_x;
    fixed_t      r_ur_y;
    fixed_t      r_x;
    fixed_t      r_y;
    logic        r_valid;

    fixed_t      w_step;
    fixed_t      w_acc_step;
    fixed_t      w_acc_mask;
    fixed_t      w_next_x;
    fixed_t      w_next_y;
    logic        w_row_end;
    logic        w_done;

    // Walk pitch comes from the latched mode; the live mode only matters at accept.
    assign w_step     = step_of(r_lg2);
    assign w_acc_step = step_of(ss_w_lg2(subSample_RnnnnU));
    assign w_acc_mask = ~(w_acc_step - fixed_t'(1));

    sample_step_gen u_step_gen (
        .i_x       (r_x),
        .i_y       (r_y),
        .i_ll_x    (r_ll_x),
        .i_ur_x    (r_ur_x),
        .i_ur_y    (r_ur_y),
        .i_step    (w_step),
        .o_next_x  (w_next_x),
        .o_next_y  (w_next_y),
        .o_row_end (w_row_end),
        .o_done    (w_done)
    );

    assign halt_R13H      = (r_state == TEST);
    assign sample_R14S[0] = r_x;
    assign sample_R14S[1] = r_y;
    assign validSamp_R14H = r_valid;
    assign lastSamp_R14H  = r_valid && w_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= WAIT;
            r_lg2   <= 2'd0;
            r_ll_x  <= '0;
            r_ur_x  <= '0;
            r_ur_y  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                WAIT: begin
                    if (validTri_R13H && !stall_R15H) begin
                        r_lg2   <= ss_w_lg2(subSample_RnnnnU);
                        r_ll_x  <= fixed_t'(box_R13S[0][0]) & w_acc_mask;
                        r_ur_x  <= fixed_t'(box_R13S[1][0]);
                        r_ur_y  <= fixed_t'(box_R13S[1][1]);
                        r_x     <= fixed_t'(box_R13S[0][0]) & w_acc_mask;
                        r_y     <= fixed_t'(box_R13S[0][1]) & w_acc_mask;
                        r_valid <= 1'b1;
                        r_state <= TEST;
                    end
                end
                TEST: begin
                    if (!stall_R15H) begin
                        if (w_done) begin
                            r_valid <= 1'b0;
                            r_state <= WAIT;
                        end else begin
                            r_x <= w_next_x;
                            r_y <= w_next_y;
                        end
                    end
                end
                default: r_state <= WAIT;
            endcase
        end
    end

    // w_row_end is consumed inside the step generator's next-position mux;
    // keep it observable here so the row boundary is visible at the top.
    logic w_row_end_unused;
    assign w_row_end_unused = w_row_end;

endmodule

// File: tb/tb_sample_walk_ctrl.sv
module tb_sample_walk_ctrl;
    import rast_pkg::*;

    logic                        clk;
    logic                        rst;
    logic                        validTri_R13H;
    logic [1:0][1:0][SIGFIG-1:0] box_R13S;
    logic [3:0]                  subSample_RnnnnU;
    logic                        stall_R15H;
    logic                        halt_R13H;
    logic [1:0][SIGFIG-1:0]      sample_R14S;
    logic                        validSamp_R14H;
    logic                        lastSamp_R14H;

    int n_checks = 0;
    int n_errors = 0;

    sample_walk_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .validTri_R13H    (validTri_R13H),
        .box_R13S         (box_R13S),
        .subSample_RnnnnU (subSample_RnnnnU),
        .stall_R15H       (stall_R15H),
        .halt_R13H        (halt_R13H),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H),
        .lastSamp_R14H    (lastSamp_R14H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ex, input int ey,
                           input logic ev, input logic el, input logic eh);
        chk({tag, " x"},     32'(signed'(sample_R14S[0])), ex);
        chk({tag, " y"},     32'(signed'(sample_R14S[1])), ey);
        chk({tag, " valid"}, {31'd0, validSamp_R14H}, {31'd0, ev});
        chk({tag, " last"},  {31'd0, lastSamp_R14H},  {31'd0, el});
        chk({tag, " halt"},  {31'd0, halt_R13H},      {31'd0, eh});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, {31'd0, validSamp_R14H}, 32'd0);
        chk({tag, " last"},  {31'd0, lastSamp_R14H},  32'd0);
        chk({tag, " halt"},  {31'd0, halt_R13H},      32'd0);
    endtask

    task automatic set_box(input int llx, input int lly, input int urx, input int ury);
        box_R13S[0][0] = SIGFIG'(llx);
        box_R13S[0][1] = SIGFIG'(lly);
        box_R13S[1][0] = SIGFIG'(urx);
        box_R13S[1][1] = SIGFIG'(ury);
    endtask

    int exp_x[6] = '{0, 1024, 2048, 0, 1024, 2048};
    int exp_y[6] = '{0, 0, 0, 1024, 1024, 1024};

    initial begin
        rst              = 1'b0;
        validTri_R13H    = 1'b0;
        stall_R15H       = 1'b0;
        subSample_RnnnnU = 4'b1000;
        set_box(0, 0, 0, 0);
        tick();
        tick();
        chk_out("reset", 0, 0, 1'b0, 1'b0, 1'b0);

        // Basic walk, 1x1, 3x2 samples
        rst = 1'b1;
        tick();
        set_box(0, 0, 2048, 1024);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_out($sformatf("basic s%0d", i), exp_x[i], exp_y[i], 1'b1, (i == 5), 1'b1);
            tick();
        end
        chk_idle("basic end");

        // Snap on 2x2 grid: single sample, degenerate after snap
        subSample_RnnnnU = 4'b0100;
        set_box(700, 300, 1023, 511);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_out("snap s0", 512, 0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_idle("snap end");

        // 8x8 grid with negative coordinates: -300 snaps to -384, step 128
        subSample_RnnnnU = 4'b0001;
        set_box(-300, 0, -100, 0);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_out("neg s0", -384, 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("neg s1", -256, 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("neg s2", -128, 0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_idle("neg end");

        // Non-one-hot mode decodes to 1x1
        subSample_RnnnnU = 4'b0011;
        set_box(1500, 0, 3000, 0);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_out("nonhot s0", 1024, 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("nonhot s1", 2048, 0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_idle("nonhot end");

        // Stall: no accept while stalled in WAIT, then freeze mid-walk
        subSample_RnnnnU = 4'b1000;
        set_box(0, 0, 1024, 1024);
        validTri_R13H = 1'b1;
        stall_R15H    = 1'b1;
        tick();
        chk_idle("stall wait");
        stall_R15H = 1'b0;
        tick();
        validTri_R13H = 1'b0;
        chk_out("stall s0", 0, 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("stall s1", 1024, 0, 1'b1, 1'b0, 1'b1);
        stall_R15H = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("stall hold%0d", i), 1024, 0, 1'b1, 1'b0, 1'b1);
        end
        stall_R15H = 1'b0;
        tick();
        chk_out("stall s2", 0, 1024, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("stall s3", 1024, 1024, 1'b1, 1'b1, 1'b1);
        tick();
        chk_idle("stall end");

        // Back-to-back with validTri held high: one bubble between boxes
        set_box(0, 0, 1024, 0);
        validTri_R13H = 1'b1;
        tick();
        chk_out("b2b a0", 0, 0, 1'b1, 1'b0, 1'b1);
        set_box(4096, 2048, 4096, 2048);
        tick();
        chk_out("b2b a1", 1024, 0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_idle("b2b bubble");
        tick();
        validTri_R13H = 1'b0;
        chk_out("b2b b0", 4096, 2048, 1'b1, 1'b1, 1'b1);
        tick();
        chk_idle("b2b end");

        // Reset during the third sample abandons the walk
        set_box(0, 0, 2048, 1024);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        tick();
        tick();
        chk_out("rstmid s2", 2048, 0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        tick();
        chk_out("rstmid reset", 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_idle("rstmid after");

        // Mode change mid-walk does not affect the pitch
        subSample_RnnnnU = 4'b1000;
        set_box(0, 0, 1024, 0);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H    = 1'b0;
        subSample_RnnnnU = 4'b0001;
        chk_out("ssmid s0", 0, 0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("ssmid s1", 1024, 0, 1'b1, 1'b1, 1'b1);
        tick();
        chk_idle("ssmid end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
